// File: rtl/mant_mul_arbiter_if.sv
// Handshake bundle between the mantissa-multiplier arbiter (slave) and its
// two requesting clients plus the result consumer (master side).
interface mant_mul_arbiter_if #(
  parameter int TAG_W = 3
);
  logic             req0_valid;
  logic             req0_ready;
  logic [23:0]      req0_a;
  logic [23:0]      req0_b;
  logic [TAG_W-1:0] req0_tag;

  logic             req1_valid;
  logic             req1_ready;
  logic [23:0]      req1_a;
  logic [23:0]      req1_b;
  logic [TAG_W-1:0] req1_tag;

  logic             resp_valid;
  logic             resp_ready;
  logic [47:0]      resp_z;
  logic             resp_src;
  logic [TAG_W-1:0] resp_tag;
  logic             resp_sticky;
  logic             busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_tag,
    input  req1_valid, req1_a, req1_b, req1_tag,
    input  resp_ready,
    output req0_ready, req1_ready,
    output resp_valid, resp_z, resp_src, resp_tag, resp_sticky, busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_tag,
    output req1_valid, req1_a, req1_b, req1_tag,
    output resp_ready,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_z, resp_src, resp_tag, resp_sticky, busy
  );
endinterface

// File: rtl/mant_mul_arbiter.sv
// Round-robin arbiter + 2-stage pipeline around the shared 24x24 mantissa multiplier.
// Define MANT_MUL_STICKY_EN to register |z[21:0] alongside the product.

// Combinational 24x24 unsigned product: partial-product array summed by a reduction tree.
module wallace_24x24_product (
  input  logic [23:0] a,
  input  logic [23:0] b,
  output logic [47:0] z
);
  logic [47:0] pp [24];

  generate
    for (genvar gi = 0; gi < 24; gi++) begin : g_pp
      assign pp[gi] = b[gi] ? ({24'd0, a} << gi) : 48'd0;
    end
  endgenerate

  always_comb begin
    z = 48'd0;
    for (int i = 0; i < 24; i++) begin
      z = z + pp[i];
    end
  end
endmodule

module mant_mul_arbiter #(
  parameter int TAG_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  mant_mul_arbiter_if.slave bus
);
  logic             s1_valid_reg;
  logic [23:0]      s1_a_reg;
  logic [23:0]      s1_b_reg;
  logic             s1_src_reg;
  logic [TAG_W-1:0] s1_tag_reg;

  logic             s2_valid_reg;
  logic [47:0]      s2_z_reg;
  logic             s2_src_reg;
  logic [TAG_W-1:0] s2_tag_reg;

  logic             prio_reg;
  logic             s1_en;
  logic             s2_en;
  logic             grant;
  logic             accept;
  logic [47:0]      product;

  wallace_24x24_product u_wallace (
    .a (s1_a_reg),
    .b (s1_b_reg),
    .z (product)
  );

  assign s2_en = !s2_valid_reg | bus.resp_ready;
  assign s1_en = !s1_valid_reg | s2_en;

  // Grant depends only on the request valids and prio, never on any ready.
  always_comb begin
    grant = bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = prio_reg;
    end
  end

  assign bus.req0_ready = s1_en & bus.req0_valid & !grant & !rst;
  assign bus.req1_ready = s1_en & bus.req1_valid &  grant & !rst;
  assign accept         = bus.req0_ready | bus.req1_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_a_reg     <= 24'd0;
      s1_b_reg     <= 24'd0;
      s1_src_reg   <= 1'b0;
      s1_tag_reg   <= '0;
      s2_valid_reg <= 1'b0;
      s2_z_reg     <= 48'd0;
      s2_src_reg   <= 1'b0;
      s2_tag_reg   <= '0;
      prio_reg     <= 1'b0;
    end else begin
      if (s2_en) begin
        s2_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          s2_z_reg   <= product;
          s2_src_reg <= s1_src_reg;
          s2_tag_reg <= s1_tag_reg;
        end
      end
      if (s1_en) begin
        s1_valid_reg <= accept;
        if (accept) begin
          s1_a_reg   <= grant ? bus.req1_a   : bus.req0_a;
          s1_b_reg   <= grant ? bus.req1_b   : bus.req0_b;
          s1_tag_reg <= grant ? bus.req1_tag : bus.req0_tag;
          s1_src_reg <= grant;
        end
      end
      if (accept) begin
        prio_reg <= ~grant;
      end
    end
  end

`ifdef MANT_MUL_STICKY_EN
  logic s2_sticky_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_sticky_reg <= 1'b0;
    end else if (s2_en && s1_valid_reg) begin
      s2_sticky_reg <= |product[21:0];
    end
  end

  assign bus.resp_sticky = s2_sticky_reg;
`else
  assign bus.resp_sticky = 1'b0;
`endif

  assign bus.resp_valid = s2_valid_reg;
  assign bus.resp_z     = s2_z_reg;
  assign bus.resp_src   = s2_src_reg;
  assign bus.resp_tag   = s2_tag_reg;
  assign bus.busy       = s1_valid_reg | s2_valid_reg;
endmodule

// File: tb/tb_mant_mul_arbiter.sv
// Scenario bench for mant_mul_arbiter: expected products are queued on accept
// and compared in order when the consumer takes each response.
module tb_mant_mul_arbiter;
  logic clk;
  logic rst;

  mant_mul_arbiter_if #(.TAG_W(3)) bus ();

  mant_mul_arbiter #(.TAG_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [47:0] z;
    logic        src;
    logic [2:0]  tag;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   resp_count = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got time=%0t, required earlier finish)", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [47:0] prod(input logic [23:0] a, input logic [23:0] b);
    logic [47:0] wa;
    logic [47:0] wb;
    wa = {24'd0, a};
    wb = {24'd0, b};
    return wa * wb;
  endfunction

  function automatic logic exp_sticky(input logic [47:0] z);
`ifdef MANT_MUL_STICKY_EN
    return |z[21:0];
`else
    return 1'b0;
`endif
  endfunction

  // Response monitor: one line per consumed result.
  always @(negedge clk) begin
    if (!rst && bus.resp_valid && bus.resp_ready) begin
      exp_t e;
      total++;
      resp_count++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL resp_unexpected: got z=%h src=%0d tag=%0d, required no response", bus.resp_z, bus.resp_src, bus.resp_tag);
      end else begin
        e = sb.pop_front();
        if (bus.resp_z !== e.z || bus.resp_src !== e.src || bus.resp_tag !== e.tag ||
            bus.resp_sticky !== exp_sticky(e.z)) begin
          bad++;
          $display("FAIL resp_data: got z=%h src=%0d tag=%0d sticky=%0d, required z=%h src=%0d tag=%0d sticky=%0d",
                   bus.resp_z, bus.resp_src, bus.resp_tag, bus.resp_sticky,
                   e.z, e.src, e.tag, exp_sticky(e.z));
        end else begin
          $display("resp t=%0t z=%h src=%0d tag=%0d sticky=%0d ok", $time, bus.resp_z, bus.resp_src, bus.resp_tag, bus.resp_sticky);
        end
      end
    end
  end

  // One clock: sample readies, queue accepted ops, advance; accepted clients present new operands.
  task automatic step(output logic r0, output logic r1);
    @(negedge clk);
    r0 = bus.req0_ready;
    r1 = bus.req1_ready;
    total++;
    if (r0 && r1) begin
      bad++;
      $display("FAIL both_ready: got req0_ready=1 req1_ready=1, required at most one");
    end
    if (r0) sb.push_back('{prod(bus.req0_a, bus.req0_b), 1'b0, bus.req0_tag});
    if (r1) sb.push_back('{prod(bus.req1_a, bus.req1_b), 1'b1, bus.req1_tag});
    @(posedge clk);
    #1;
    if (r0) begin
      bus.req0_a   = 24'($urandom) | 24'h800000;
      bus.req0_b   = 24'($urandom) | 24'h800000;
      bus.req0_tag = bus.req0_tag + 3'd1;
    end
    if (r1) begin
      bus.req1_a   = 24'($urandom) | 24'h800000;
      bus.req1_b   = 24'($urandom) | 24'h800000;
      bus.req1_tag = bus.req1_tag + 3'd1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      if (sb.size() == 0 && !bus.busy) break;
      @(posedge clk);
      #1;
    end
    total++;
    if (sb.size() != 0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL drain_timeout: got pending=%0d busy=%0d, required pending=0 busy=0", sb.size(), bus.busy);
    end
  endtask

  task automatic test_reset();
    logic r0, r1;
    @(negedge clk);
    total++;
    if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0 ||
        bus.resp_z !== 48'd0 || bus.resp_tag !== 3'd0 || bus.resp_src !== 1'b0 || bus.resp_sticky !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got rv=%0d busy=%0d r0=%0d r1=%0d z=%h tag=%0d src=%0d st=%0d, required all 0",
               bus.resp_valid, bus.busy, bus.req0_ready, bus.req1_ready, bus.resp_z, bus.resp_tag, bus.resp_src, bus.resp_sticky);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    // Accept one op, then reset while it is in flight.
    bus.req0_valid = 1'b1;
    step(r0, r1);
    bus.req0_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0) begin
        bad++;
        $display("FAIL reset_mid_op: got resp_valid=%0d busy=%0d, required 0 0", bus.resp_valid, bus.busy);
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0) begin
        bad++;
        $display("FAIL reset_no_stale: got resp_valid=%0d busy=%0d, required 0 0", bus.resp_valid, bus.busy);
      end
    end
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    step(r0, r1);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    total++;
    if (r0 !== 1'b1 || r1 !== 1'b0) begin
      bad++;
      $display("FAIL reset_prio: got r0=%0d r1=%0d, required r0=1 r1=0", r0, r1);
    end
    drain();
  endtask

  task automatic test_single_op();
    logic r0, r1;
    bus.req0_a = 24'h800000;
    bus.req0_b = 24'h800000;
    bus.req0_tag = 3'd5;
    bus.req0_valid = 1'b1;
    step(r0, r1);
    bus.req0_valid = 1'b0;
    total++;
    if (r0 !== 1'b1) begin
      bad++;
      $display("FAIL single_ready: got req0_ready=%0d, required 1", r0);
    end
    total++;
    if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL single_latency: got resp_valid=%0d busy=%0d, required 0 1", bus.resp_valid, bus.busy);
    end
    @(posedge clk);
    #1;
    total++;
    if (bus.resp_valid !== 1'b1 || bus.resp_z !== 48'h400000000000 || bus.resp_src !== 1'b0 ||
        bus.resp_tag !== 3'd5 || bus.resp_sticky !== 1'b0) begin
      bad++;
      $display("FAIL single_result: got rv=%0d z=%h src=%0d tag=%0d st=%0d, required 1 400000000000 0 5 0",
               bus.resp_valid, bus.resp_z, bus.resp_src, bus.resp_tag, bus.resp_sticky);
    end
    drain();
  endtask

  task automatic test_max_operands();
    logic r0, r1;
    logic st;
    bus.req1_a = 24'hFFFFFF;
    bus.req1_b = 24'hFFFFFF;
    bus.req1_valid = 1'b1;
    step(r0, r1);
    bus.req1_valid = 1'b0;
    total++;
    if (r1 !== 1'b1) begin
      bad++;
      $display("FAIL max_ready: got req1_ready=%0d, required 1", r1);
    end
    @(posedge clk);
    #1;
`ifdef MANT_MUL_STICKY_EN
    st = 1'b1;
`else
    st = 1'b0;
`endif
    total++;
    if (bus.resp_valid !== 1'b1 || bus.resp_z !== 48'hFFFFFE000001 || bus.resp_src !== 1'b1 || bus.resp_sticky !== st) begin
      bad++;
      $display("FAIL max_result: got rv=%0d z=%h src=%0d st=%0d, required 1 fffffe000001 1 %0d",
               bus.resp_valid, bus.resp_z, bus.resp_src, bus.resp_sticky, st);
    end
    drain();
  endtask

  task automatic test_round_robin();
    logic r0, r1;
    int   start_count;
    bus.resp_ready = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i >= 2) begin
        total++;
        if (bus.resp_valid !== 1'b1) begin
          bad++;
          $display("FAIL rr_throughput: cycle %0d got resp_valid=%0d, required 1", i, bus.resp_valid);
        end
      end
      step(r0, r1);
      total++;
      if (r1 !== 1'(i % 2) || r0 !== 1'((i + 1) % 2)) begin
        bad++;
        $display("FAIL rr_grant: cycle %0d got r0=%0d r1=%0d, required grant to client %0d", i, r0, r1, i % 2);
      end
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    start_count = resp_count;
    drain();
    total++;
    if (resp_count - start_count != 2) begin
      bad++;
      $display("FAIL rr_tail: got %0d trailing responses, required 2", resp_count - start_count);
    end
  endtask

  task automatic test_backpressure();
    logic r0, r1;
    int   accepted;
    bus.resp_ready = 1'b0;
    bus.req0_valid = 1'b1;
    accepted = 0;
    for (int i = 0; i < 2; i++) begin
      step(r0, r1);
      if (r0) accepted++;
    end
    total++;
    if (accepted != 2) begin
      bad++;
      $display("FAIL bp_fill: got %0d accepted, required 2", accepted);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (bus.resp_valid !== 1'b1 || sb.size() == 0 || bus.resp_z !== sb[0].z || bus.busy !== 1'b1) begin
        bad++;
        $display("FAIL bp_hold: cycle %0d got rv=%0d z=%h busy=%0d, required held first result", i, bus.resp_valid, bus.resp_z, bus.busy);
      end
      step(r0, r1);
      total++;
      if (r0 !== 1'b0) begin
        bad++;
        $display("FAIL bp_ready: cycle %0d got req0_ready=%0d, required 0", i, r0);
      end
    end
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 10 && accepted < 3; i++) begin
      step(r0, r1);
      if (r0) accepted++;
    end
    bus.req0_valid = 1'b0;
    total++;
    if (accepted != 3) begin
      bad++;
      $display("FAIL bp_release: got %0d accepted, required 3", accepted);
    end
    drain();
  endtask

  task automatic test_single_client();
    logic r0, r1;
    bus.req1_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(r0, r1);
      total++;
      if (r1 !== 1'b1 || r0 !== 1'b0) begin
        bad++;
        $display("FAIL fair_grant: cycle %0d got r0=%0d r1=%0d, required 0 1", i, r0, r1);
      end
    end
    bus.req1_valid = 1'b0;
    drain();
  endtask

  initial begin
    rst = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req0_a     = 24'h800001;
    bus.req0_b     = 24'hC00000;
    bus.req0_tag   = 3'd0;
    bus.req1_valid = 1'b0;
    bus.req1_a     = 24'hA00000;
    bus.req1_b     = 24'h900003;
    bus.req1_tag   = 3'd4;
    bus.resp_ready = 1'b1;

    test_reset();
    test_single_op();
    test_max_operands();
    test_round_robin();
    test_backpressure();
    test_single_client();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mant_mul_arbiter.md
# mant_mul_arbiter

Two-requester arbiter and pipeline controller for the shared 24x24 Wallace mantissa multiplier in the RISCV32F datapath. It accepts operand pairs from two clients (req0: FMUL/FMADD unit, req1: FDIV/FSQRT iteration unit) over valid/ready handshakes and grants them round-robin. It registers the operands, drives the combinational `wallace_24x24_product` instance, and returns the registered 48-bit product with source ID and tag. It propagates backpressure from the consumer without dropping or duplicating transactions.

## Interface
- `TAG_W`, 3: width of the opaque tag carried from request to response.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req0_valid`  in  1  client 0 has an operand pair.
- `req0_ready`  out  1  client 0 transfer accepted this cycle.
- `req0_a`, `req0_b`  in  24 each  client 0 mantissas (hidden bit included).
- `req0_tag`  in  TAG_W  client 0 tag.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_tag`: same as client 0, for client 1.
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  consumer accepts the result.
- `resp_z`  out  48  unsigned product a*b.
- `resp_src`  out  1  originating client, 0 or 1.
- `resp_tag`  out  TAG_W  tag of the originating request.
- `resp_sticky`  out  1  OR of `resp_z[21:0]`. Tied to 0 when the feature is disabled (see Configuration).
- `busy`  out  1  `s1_valid | s2_valid`.

## Operation
- **S1 (operand register):** holds a, b, src, tag and `s1_valid`. The Wallace instance is driven from the S1 a/b registers.
- **S2 (result register):** holds z, src, tag, sticky and `s2_valid`. The `resp_*` outputs come directly from the S2 registers.
- **Enables:** `s2_en = !s2_valid | resp_ready`; `s1_en = !s1_valid | s2_en`.
- On `s2_en`, S2 loads from S1, and `s2_valid` takes the value of `s1_valid`.
- On `s1_en`, S1 loads the granted request, and `s1_valid` is set to whether any request was accepted.
- **Grant:** combinational, a function of `req*_valid` and the priority bit `prio` only, never of `resp_ready` or any `*_ready`.
  - Only one client valid: that client is granted.
  - Both clients valid: the client equal to `prio` is granted.
- `reqN_ready = s1_en & grant==N`. At most one ready is high per cycle.
- **Priority update:** on an accepted transfer from client N, `prio <= ~N`. Otherwise `prio` holds.
- **Client rules:** a client keeps valid, a, b and tag stable until it sees ready. The arbiter never withdraws a grant before the transfer, and is correct even if a client withdraws valid.
- **Arithmetic:** `resp_z` is the full unsigned 48-bit product with no truncation or rounding. Normalization and rounding belong to the consumer.
- **Concurrent transfers:** S2 drains while S1 refills in the same cycle, giving full throughput of one op per cycle when `resp_ready` is held high.
- **Stall:** S2 holds its contents while `resp_valid & !resp_ready`. S1 holds if it is also valid, and both readies are low.
- **Reset:** `s1_valid`, `s2_valid`, `resp_valid`, `req0_ready`, `req1_ready`, `busy`, `resp_sticky`, `resp_src` are 0, `prio` is 0, `resp_z` is 0, `resp_tag` is 0. All in-flight operations are discarded with no response. Reset can assert in any cycle.

## Timing
- **Latency:** a request accepted at rising edge N gives `resp_valid` high after edge N+1. It is visible in cycle N+1→N+2, two cycles after valid was presented.
- **Throughput:** one result per cycle with no stall.
- **Critical path:** S1 register → Wallace tree + final CPA → S2 register. No other logic sits on that path.
- **Combinational paths:** `resp_ready` → `req*_ready` is allowed (via `s2_en`/`s1_en`). `req*_valid` → `req*_ready` is allowed. No path from `resp_ready` to `resp_valid`.

## Configuration
- `MANT_MUL_STICKY_EN` defined:
  - S2 also registers `|z[21:0]` computed from the Wallace output.
  - `resp_sticky` is valid together with `resp_valid`.
- `MANT_MUL_STICKY_EN` undefined:
  - No sticky logic or flop is built.
  - `resp_sticky` is constant 0.
- Latency and handshake are identical in both builds.

## Test plan
- **Reset mid-operation:**
  - Stimulus: issue a request and assert `rst` one cycle later.
  - Check: `resp_valid` and `busy` are 0 during and after reset, no stale response appears, and `prio` is 0. The first post-reset simultaneous request grants client 0.
- **Single op:**
  - Stimulus: req0 a=24'h800000, b=24'h800000, tag=5.
  - Check: `req0_ready`=1 the same cycle. Two cycles later, `resp_valid`=1, `resp_z`=48'h400000000000, `resp_src`=0, `resp_tag`=5, `resp_sticky`=0.
- **Max operands with sticky:**
  - Stimulus: req1 a=b=24'hFFFFFF.
  - Check: `resp_z`=48'hFFFFFE000001, `resp_src`=1, and `resp_sticky`=1 with `MANT_MUL_STICKY_EN` (0 without it).
- **Round-robin:**
  - Stimulus: both clients valid continuously for 6 cycles with `resp_ready`=1.
  - Check: grants alternate 0,1,0,1,0,1, and responses arrive in order, one per cycle, with matching tags.
- **Backpressure:**
  - Stimulus: stream 3 ops from req0 and hold `resp_ready`=0 for 4 cycles.
  - Check: `resp_valid` stays high with the first result held stable. S1 holds op 2. `req0_ready` is 0 while both stages are full. After release, all 3 results emerge in order, none lost or duplicated.
- **Single-client fairness:**
  - Stimulus: only req1 valid for 3 cycles.
  - Check: req1 is granted every cycle regardless of `prio`.
